fetch_queue: RTL and testbench

- Parametrised instruction queue between the fetch SRAM return and the decoders; successor of the fixed two-slot ID front end.
- Accepts FETCH_W-wide aligned fetch packets and tracks the expected PC, so it drops stale or misaligned packets and leading slots before a branch target.
- Buffers up to DEPTH instructions and presents the oldest ISSUE_W in program order with an explicit consume count.
- Adds an enqueue/dequeue handshake and branch flush, which the fixed two-slot version lacks.

---
 rtl/fetch_queue_pkg.sv | 23 ++
 rtl/fq_align.sv | 50 +++++
 rtl/fetch_queue.sv | 120 ++++++++++++
 tb/tb_fetch_queue.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared constants and types for the fetch queue: default geometry, the boot PC
// and the packed entry format stored in the queue.
package fetch_queue_pkg;

  localparam int          FQ_FETCH_W  = 2;
  localparam int          FQ_ISSUE_W  = 2;
  localparam int          FQ_DEPTH    = 8;
  localparam logic [31:0] FQ_RESET_PC = 32'hbfc0_0000;

  // Flattened widths of an incoming packet (inst + pc + valid) and of the issue bundle.
  localparam int FQ_PKT_WD = FQ_FETCH_W * 32 + 32 + 1;
  localparam int FQ_OUT_WD = FQ_ISSUE_W * 64 + FQ_ISSUE_W;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fq_entry_t;

  function automatic int fq_slot_w(input int fetch_w);
    return (fetch_w > 1) ? $clog2(fetch_w) : 1;
  endfunction

endpackage

// File: rtl/fq_align.sv
// Compacts the live slots of a fetch packet (those at or after the entry slot)
// down to lane 0 so the queue can write them to consecutive entries from tail.
module fq_align
  import fetch_queue_pkg::*;
#(
  parameter int FETCH_W = FQ_FETCH_W
) (
  input  logic [FETCH_W*32-1:0]          in_inst,
  input  logic [31:0]                    in_pc,
  input  logic [fq_slot_w(FETCH_W)-1:0]  start,
  output logic [FETCH_W-1:0]             wr_en,
  output logic [FETCH_W*32-1:0]          wr_inst,
  output logic [FETCH_W*32-1:0]          wr_pc,
  output logic [$clog2(FETCH_W):0]       num
);

  localparam int          SLOT_W    = fq_slot_w(FETCH_W);
  localparam int          NUM_W     = $clog2(FETCH_W) + 1;
  localparam logic [31:0] PKT_BYTES = 32'(FETCH_W * 4);

  logic [31:0]       base;
  logic [31:0]       slot_inst [FETCH_W];
  logic [SLOT_W:0]   src;

  for (genvar k = 0; k < FETCH_W; k++) begin : g_slot
    assign slot_inst[k] = in_inst[32*k +: 32];
  end

  assign base = in_pc & ~(PKT_BYTES - 32'd1);
  assign num  = NUM_W'(FETCH_W) - NUM_W'(start);

  // Lane j carries packet slot start+j when that slot exists.
  always_comb begin
    wr_en   = {FETCH_W{1'b0}};
    wr_inst = {(FETCH_W*32){1'b0}};
    wr_pc   = {(FETCH_W*32){1'b0}};
    src     = {(SLOT_W+1){1'b0}};
    for (int j = 0; j < FETCH_W; j++) begin
      src = {1'b0, start} + (SLOT_W+1)'(j);
      if (src < (SLOT_W+1)'(FETCH_W)) begin
        wr_en[j]          = 1'b1;
        wr_inst[32*j +: 32] = slot_inst[src[SLOT_W-1:0]];
        wr_pc[32*j +: 32]   = base + 32'({src, 2'b00});
      end else begin
        wr_en[j] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction queue between fetch return and decode: filters packets against the
// expected PC, buffers up to DEPTH instructions and issues the oldest ISSUE_W.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          FETCH_W  = FQ_FETCH_W,
  parameter int          ISSUE_W  = FQ_ISSUE_W,
  parameter int          DEPTH    = FQ_DEPTH,
  parameter logic [31:0] RESET_PC = FQ_RESET_PC
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      br_e,
  input  logic [31:0]               br_addr,
  input  logic                      in_valid,
  input  logic [31:0]               in_pc,
  input  logic [FETCH_W*32-1:0]     in_inst,
  output logic                      in_ready,
  output logic [ISSUE_W-1:0]        out_valid,
  output logic [ISSUE_W*32-1:0]     out_pc,
  output logic [ISSUE_W*32-1:0]     out_inst,
  input  logic [$clog2(ISSUE_W):0]  deq_num,
  output logic [15:0]               drop_cnt
);

  localparam int          ALIGN     = $clog2(FETCH_W * 4);
  localparam int          PTR_W     = $clog2(DEPTH);
  localparam int          CNT_W     = PTR_W + 1;
  localparam int          SLOT_W    = fq_slot_w(FETCH_W);
  localparam logic [31:0] PKT_BYTES = 32'(FETCH_W * 4);

  fq_entry_t              mem [DEPTH];
  logic [PTR_W-1:0]       head;
  logic [PTR_W-1:0]       tail;
  logic [CNT_W-1:0]       count;
  logic [31:0]            exp_pc;

  logic [SLOT_W-1:0]      start;
  logic                   tag_match;
  logic                   accept;
  logic                   drop;
  logic [31:0]            pkt_base;
  logic [CNT_W-1:0]       enq_n;
  logic [CNT_W-1:0]       deq_n;
  logic [FETCH_W-1:0]     wr_en;
  logic [FETCH_W*32-1:0]  wr_inst;
  logic [FETCH_W*32-1:0]  wr_pc;
  logic [$clog2(FETCH_W):0] num;
  logic                   unused_bits;

  if (FETCH_W > 1) begin : g_start
    assign start = exp_pc[ALIGN-1:2];
  end else begin : g_start_zero
    assign start = {SLOT_W{1'b0}};
  end

  assign in_ready    = (CNT_W'(DEPTH) - count) >= CNT_W'(FETCH_W);
  assign tag_match   = in_pc[31:ALIGN] == exp_pc[31:ALIGN];
  assign accept      = in_valid & in_ready & ~br_e & tag_match;
  assign drop        = in_valid & in_ready & ~br_e & ~tag_match;
  assign pkt_base    = {in_pc[31:ALIGN], {ALIGN{1'b0}}};
  assign enq_n       = accept ? CNT_W'(num) : {CNT_W{1'b0}};
  assign deq_n       = CNT_W'(deq_num);
  assign unused_bits = ^{br_addr[1:0], exp_pc[1:0]};

  fq_align #(.FETCH_W(FETCH_W)) u_align (
    .in_inst (in_inst),
    .in_pc   (in_pc),
    .start   (start),
    .wr_en   (wr_en),
    .wr_inst (wr_inst),
    .wr_pc   (wr_pc),
    .num     (num)
  );

  // Queue state: reset beats flush, flush beats enqueue/dequeue.
  always_ff @(posedge clk) begin
    if (reset) begin
      head     <= {PTR_W{1'b0}};
      tail     <= {PTR_W{1'b0}};
      count    <= {CNT_W{1'b0}};
      exp_pc   <= RESET_PC;
      drop_cnt <= 16'd0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (br_e) begin
      head   <= {PTR_W{1'b0}};
      tail   <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
      exp_pc <= {br_addr[31:2], 2'b00};
    end else begin
      for (int j = 0; j < FETCH_W; j++) begin
        if (accept && wr_en[j]) begin
          mem[tail + PTR_W'(j)] <= '{pc: wr_pc[32*j +: 32], inst: wr_inst[32*j +: 32]};
        end
      end
      if (accept) begin
        tail   <= tail + PTR_W'(num);
        exp_pc <= pkt_base + PKT_BYTES;
      end
      if (drop && (drop_cnt != 16'hffff)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
      head  <= head + deq_n[PTR_W-1:0];
      count <= count + enq_n - deq_n;
    end
  end

  // Issue window: slot i shows entry head+i.
  always_comb begin
    out_valid = {ISSUE_W{1'b0}};
    out_pc    = {(ISSUE_W*32){1'b0}};
    out_inst  = {(ISSUE_W*32){1'b0}};
    for (int i = 0; i < ISSUE_W; i++) begin
      out_valid[i]       = count > CNT_W'(i);
      out_pc[32*i +: 32]   = mem[head + PTR_W'(i)].pc;
      out_inst[32*i +: 32] = mem[head + PTR_W'(i)].inst;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a driver applies directed then random traffic
// and queues expected entries; a monitor retires and compares them every cycle.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int          FETCH_W  = 2;
  localparam int          ISSUE_W  = 2;
  localparam int          DEPTH    = 8;
  localparam int          ALIGN    = 3;
  localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

  logic        clk = 1'b0;
  logic        reset, br_e, in_valid, in_ready;
  logic [31:0] br_addr, in_pc;
  logic [63:0] in_inst, out_pc, out_inst;
  logic [1:0]  out_valid, deq_num;
  logic [15:0] drop_cnt;

  fetch_queue #(.FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .br_e(br_e), .br_addr(br_addr),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .deq_num(deq_num), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        sb[$];
  logic [31:0] mexp;
  int          mdrop;
  bit          mon_en;
  int          n_checks;
  int          n_fail;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs (caller is at a negedge) and advance the reference model.
  task automatic drive(input bit rst, input bit br, input logic [31:0] ba, input bit v,
                       input logic [31:0] pc, input logic [63:0] inst, input int dq);
    int sz = sb.size();
    int mx = (sz < ISSUE_W) ? sz : ISSUE_W;
    int d  = (dq > mx) ? mx : dq;
    reset = rst; br_e = br; br_addr = ba; in_valid = v; in_pc = pc; in_inst = inst;
    deq_num = 2'(d);
    if (rst) begin
      sb.delete(); mexp = RESET_PC; mdrop = 0; mon_en = 1'b1;
    end else if (br) begin
      sb.delete(); mexp = {ba[31:2], 2'b00};
    end else if (v && (DEPTH - sz) >= FETCH_W) begin
      if ((pc >> ALIGN) == (mexp >> ALIGN)) begin
        logic [31:0] base = (pc >> ALIGN) << ALIGN;
        for (int s = (mexp >> 2) % FETCH_W; s < FETCH_W; s++) begin
          ent_t e;
          e.pc   = base + 32'(s * 4);
          e.inst = inst[32*s +: 32];
          sb.push_back(e);
        end
        mexp = base + 32'(FETCH_W * 4);
      end else begin
        mdrop = (mdrop == 65535) ? 65535 : mdrop + 1;
      end
    end
  endtask

  task automatic cyc(input bit rst, input bit br, input logic [31:0] ba, input bit v,
                     input logic [31:0] pc, input logic [63:0] inst, input int dq);
    @(negedge clk);
    drive(rst, br, ba, v, pc, inst, dq);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  bit               m_en, m_flush, m_rst;
  int               m_deq;
  logic [1:0]       m_expv;

  // Monitor: retire consumed entries, then compare the visible window with the scoreboard.
  initial forever begin
    @(posedge clk);
    m_en = mon_en; m_deq = int'(deq_num); m_flush = br_e; m_rst = reset;
    #1;
    if (m_en) begin
      if (!m_rst && !m_flush) begin
        for (int k = 0; k < m_deq; k++) if (sb.size() > 0) void'(sb.pop_front());
      end
      m_expv = 2'b00;
      for (int i = 0; i < ISSUE_W; i++) if (sb.size() > i) m_expv[i] = 1'b1;
      check("out_valid", out_valid, m_expv);
      for (int i = 0; i < ISSUE_W; i++) begin
        if (sb.size() > i) begin
          check("out_pc", out_pc[32*i +: 32], sb[i].pc);
          check("out_inst", out_inst[32*i +: 32], sb[i].inst);
        end
      end
      check("in_ready", in_ready, (DEPTH - sb.size()) >= FETCH_W);
      check("drop_cnt", drop_cnt, mdrop);
    end
  end

  initial begin
    reset = 1'b1; br_e = 1'b0; br_addr = 32'd0; in_valid = 1'b0;
    in_pc = 32'd0; in_inst = 64'd0; deq_num = 2'd0;
    mon_en = 1'b0; n_checks = 0; n_fail = 0; mexp = RESET_PC; mdrop = 0;

    cyc(1, 0, 0, 0, 0, 0, 0); settle();
    check("rst_valid", out_valid, 2'b00);
    check("rst_ready", in_ready, 1'b1);
    check("rst_pc", out_pc, 64'd0);
    check("rst_inst", out_inst, 64'd0);
    check("rst_drop", drop_cnt, 16'd0);

    cyc(0, 0, 0, 1, 32'hbfc0_0000, {32'h2222_0002, 32'h1111_0001}, 0); settle();
    check("first_valid", out_valid, 2'b11);
    check("first_pc", out_pc, {32'hbfc0_0004, 32'hbfc0_0000});
    check("first_inst", out_inst, {32'h2222_0002, 32'h1111_0001});

    cyc(0, 0, 0, 1, 32'hbfc0_0200, {32'hdead_0002, 32'hdead_0001}, 0); settle();
    check("stale_drop", drop_cnt, 16'd1);
    check("stale_valid", out_valid, 2'b11);
    cyc(0, 0, 0, 1, 32'hbfc0_0008, {32'h4444_0004, 32'h3333_0003}, 0); settle();

    // Flush wins over the packet and the dequeue issued with it.
    cyc(0, 1, 32'hbfc0_0104, 1, 32'hbfc0_0008, {32'h5, 32'h6}, 1); settle();
    check("flush_valid", out_valid, 2'b00);
    check("flush_ready", in_ready, 1'b1);
    cyc(0, 0, 0, 1, 32'hbfc0_0100, {32'h7777_000b, 32'h6666_000a}, 0); settle();
    check("target_valid", out_valid, 2'b01);
    check("target_pc", out_pc[31:0], 32'hbfc0_0104);
    check("target_inst", out_inst[31:0], 32'h7777_000b);
    cyc(0, 0, 0, 1, 32'hbfc0_0108, {$urandom, $urandom}, 0);

    // Fill to DEPTH, try an ignored packet, then free space and wrap the tail.
    cyc(0, 1, 32'hbfc0_0000, 0, 0, 0, 0);
    for (int p = 0; p < 4; p++) cyc(0, 0, 0, 1, 32'hbfc0_0000 + 32'(p * 8), {$urandom, $urandom}, 0);
    settle();
    check("full_ready", in_ready, 1'b0);
    check("full_valid", out_valid, 2'b11);
    cyc(0, 0, 0, 1, 32'hbfc0_0020, {$urandom, $urandom}, 0); settle();
    check("full_nodrop", drop_cnt, 16'd1);
    cyc(0, 0, 0, 0, 0, 0, 2); settle();
    check("free_ready", in_ready, 1'b1);
    cyc(0, 0, 0, 1, 32'hbfc0_0020, {32'haaaa_0002, 32'haaaa_0001}, 0);
    cyc(0, 0, 0, 0, 0, 0, 2);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 32'hbfc0_0028, {$urandom, $urandom}, 1); settle();
    check("mix_ready", in_ready, 1'b1);
    cyc(0, 1, 32'hbfc0_0300, 1, 32'hbfc0_0030, {$urandom, $urandom}, 2); settle();
    check("mixflush_valid", out_valid, 2'b00);

    for (int p = 0; p < 3; p++) cyc(0, 0, 0, 1, 32'hbfc0_0300 + 32'(p * 8), {$urandom, $urandom}, 0);
    cyc(1, 0, 0, 1, 32'hbfc0_0318, {$urandom, $urandom}, 1); settle();
    check("midrst_valid", out_valid, 2'b00);
    check("midrst_ready", in_ready, 1'b1);
    check("midrst_drop", drop_cnt, 16'd0);
    cyc(0, 0, 0, 1, 32'hbfc0_0000, {$urandom, $urandom}, 0); settle();
    check("midrst_exp_pc", out_pc, {32'hbfc0_0004, 32'hbfc0_0000});

    for (int c = 0; c < 3000; c++) begin
      logic [31:0] pc;
      int r, k;
      @(negedge clk);
      r = int'($urandom_range(0, 9));
      k = int'($urandom_range(0, 4)) - 2;
      if (r < 6)      pc = {mexp[31:ALIGN], 3'($urandom)};
      else if (r < 8) pc = mexp + 32'(k * 8);
      else            pc = $urandom;
      drive($urandom_range(0, 399) == 0, $urandom_range(0, 24) == 0,
            {mexp[31:12], 12'($urandom)}, $urandom_range(0, 3) != 0, pc,
            {$urandom, $urandom}, int'($urandom_range(0, ISSUE_W)));
    end
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
